// File: rtl/motor_ramp_ctrl_if.sv
// Command channel into the motor ramp controller: valid/ready with channel, direction and duty.
interface motor_ramp_ctrl_if #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned DUTY_W = 10
) ();
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CH_W-1:0]   cmd_ch;
    logic [1:0]        cmd_dir;
    logic [DUTY_W-1:0] cmd_duty;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_dir,
        output cmd_duty,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ch,
        input  cmd_dir,
        input  cmd_duty,
        output cmd_ready
    );
endinterface

// File: rtl/motor_ramp_ctrl.sv
// N-channel H-bridge driver: ramped duty, dead-time on reversal, brake, shared PWM period counter.
module motor_ramp_ctrl #(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned DUTY_W    = 10,
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned PWM_HZ    = 25_000,
    parameter int unsigned RAMP_DIV  = 100_000,
    parameter int unsigned RAMP_STEP = 8,
    parameter int unsigned DEAD_CYC  = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    motor_ramp_ctrl_if.slave     cmd,
    input  logic                 estop,
    output logic [N_CH-1:0]      pwm,
    output logic [2*N_CH-1:0]    motor_in,
    output logic [N_CH-1:0]      busy
);
    localparam int unsigned PERIOD = CLK_HZ / PWM_HZ;
    localparam int unsigned CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned RDIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRun   = 3'd1;
    localparam logic [2:0] StDecel = 3'd2;
    localparam logic [2:0] StDead  = 3'd3;
    localparam logic [2:0] StBrake = 3'd4;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RDIV_W-1:0] ramp_q, ramp_d;
    logic              wrap, tick, ready, cmd_hit;

    logic [N_CH-1:0][2:0]        state_q, state_d;
    logic [N_CH-1:0][1:0]        dir_q, dir_d;
    logic [N_CH-1:0][1:0]        tgt_dir_q, tgt_dir_d;
    logic [N_CH-1:0][DUTY_W-1:0] tgt_duty_q, tgt_duty_d;
    logic [N_CH-1:0][DUTY_W-1:0] cur_q, cur_d;
    logic [N_CH-1:0][CNT_W-1:0]  thr_q, thr_d;
    logic [N_CH-1:0][DEAD_W-1:0] dead_q, dead_d;
    logic [N_CH-1:0]             pwm_q, pwm_d;

    logic        sel, e_brake, e_stop, drive;
    logic [31:0] prod;

    // Step cur toward tgt by RAMP_STEP, landing exactly on tgt when closer than one step.
    function automatic logic [DUTY_W-1:0] ramp_to(input logic [DUTY_W-1:0] cur,
                                                  input logic [DUTY_W-1:0] tgt);
        int unsigned c, t;
        c = 32'(cur);
        t = 32'(tgt);
        if (c + RAMP_STEP <= t) return DUTY_W'(c + RAMP_STEP);
        else if (t + RAMP_STEP <= c) return DUTY_W'(c - RAMP_STEP);
        else return tgt;
    endfunction

    assign ready         = !rst && !estop;
    assign cmd.cmd_ready = ready;
    assign wrap          = (cnt_q == CNT_W'(PERIOD - 1));
    assign tick          = (ramp_q == RDIV_W'(RAMP_DIV - 1));
    assign pwm           = pwm_q;

    // Shared period and ramp-tick counters.
    always_comb begin
        cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
        ramp_d = tick ? '0 : ramp_q + RDIV_W'(1);
    end

    // Per-channel FSM, ramp and threshold next-state; a command accepted this cycle steers
    // state decisions immediately while the ramp still follows the previously held target.
    always_comb begin
        cmd_hit    = cmd.cmd_valid && ready && (32'(cmd.cmd_ch) < N_CH);
        state_d    = state_q;
        dir_d      = dir_q;
        tgt_dir_d  = tgt_dir_q;
        tgt_duty_d = tgt_duty_q;
        cur_d      = cur_q;
        dead_d     = dead_q;
        thr_d      = thr_q;
        pwm_d      = '0;
        sel        = 1'b0;
        e_brake    = 1'b0;
        e_stop     = 1'b0;
        drive      = 1'b0;
        prod       = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            sel = cmd_hit && (32'(cmd.cmd_ch) == k);
            if (sel) begin
                tgt_dir_d[k]  = cmd.cmd_dir;
                tgt_duty_d[k] = cmd.cmd_duty;
            end
            e_brake = (tgt_dir_d[k] == 2'b11);
            e_stop  = !e_brake && ((tgt_dir_d[k] == 2'b00) || (tgt_duty_d[k] == '0));
            case (state_q[k])
                StIdle: begin
                    cur_d[k] = '0;
                    if (e_brake) begin
                        state_d[k] = StBrake;
                    end else if (!e_stop) begin
                        state_d[k] = StRun;
                        dir_d[k]   = tgt_dir_d[k];
                    end
                end
                StRun: begin
                    if (e_brake) begin
                        state_d[k] = StBrake;
                        cur_d[k]   = '0;
                    end else if (e_stop || (tgt_dir_d[k] != dir_q[k])) begin
                        state_d[k] = StDecel;
                    end else if (tick) begin
                        cur_d[k] = ramp_to(cur_q[k], tgt_duty_q[k]);
                    end
                end
                StDecel: begin
                    if (e_brake) begin
                        state_d[k] = StBrake;
                        cur_d[k]   = '0;
                    end else if (cur_q[k] == '0) begin
                        state_d[k] = e_stop ? StIdle : StDead;
                        dead_d[k]  = '0;
                    end else if (tick) begin
                        cur_d[k] = ramp_to(cur_q[k], '0);
                    end
                end
                StDead: begin
                    if (dead_q[k] == DEAD_W'(DEAD_CYC - 1)) begin
                        dead_d[k] = '0;
                        if (e_brake) begin
                            state_d[k] = StBrake;
                        end else if (e_stop) begin
                            state_d[k] = StIdle;
                        end else begin
                            state_d[k] = StRun;
                            dir_d[k]   = tgt_dir_d[k];
                        end
                    end else begin
                        dead_d[k] = dead_q[k] + DEAD_W'(1);
                    end
                end
                StBrake: begin
                    cur_d[k] = '0;
                    if (!e_brake) begin
                        state_d[k] = StDead;
                        dead_d[k]  = '0;
                    end
                end
                default: state_d[k] = StIdle;
            endcase
            if (estop) begin
                state_d[k]    = StIdle;
                cur_d[k]      = '0;
                dir_d[k]      = '0;
                tgt_dir_d[k]  = '0;
                tgt_duty_d[k] = '0;
                dead_d[k]     = '0;
            end
            // Threshold is zeroed whenever the bridge is not driven so no stale duty leaks
            // into a new direction before the next period boundary.
            drive    = (state_d[k] == StRun) || (state_d[k] == StDecel);
            prod     = 32'(PERIOD) * 32'(cur_q[k]);
            thr_d[k] = !drive ? '0 : (wrap ? CNT_W'(prod >> DUTY_W) : thr_q[k]);
            pwm_d[k] = drive && (cnt_q < thr_q[k]);
        end
    end

    // Bridge inputs and busy flags decoded from the held state.
    always_comb begin
        motor_in = '0;
        busy     = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            case (state_q[k])
                StRun, StDecel: motor_in[2*k +: 2] = dir_q[k];
                StBrake:        motor_in[2*k +: 2] = 2'b11;
                default:        motor_in[2*k +: 2] = 2'b00;
            endcase
            if (estop) motor_in[2*k +: 2] = 2'b00;
            busy[k] = (state_q[k] == StDecel) || (state_q[k] == StDead) ||
                      ((state_q[k] == StRun) && (cur_q[k] != tgt_duty_q[k]));
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            ramp_q     <= '0;
            state_q    <= '0;
            dir_q      <= '0;
            tgt_dir_q  <= '0;
            tgt_duty_q <= '0;
            cur_q      <= '0;
            thr_q      <= '0;
            dead_q     <= '0;
            pwm_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            ramp_q     <= ramp_d;
            state_q    <= state_d;
            dir_q      <= dir_d;
            tgt_dir_q  <= tgt_dir_d;
            tgt_duty_q <= tgt_duty_d;
            cur_q      <= cur_d;
            thr_q      <= thr_d;
            dead_q     <= dead_d;
            pwm_q      <= pwm_d;
        end
    end
endmodule

// File: doc/motor_ramp_ctrl.md
Name: motor_ramp_ctrl

Overview:
- N-channel DC motor driver for an H-bridge such as the L298N. It replaces the fixed two-motor, fixed-speed controller.
- Each channel accepts a direction and target duty from a valid/ready command port. Actual duty ramps toward the target at a programmable rate (soft start and soft stop).
- A direction reversal always passes through ramp-to-zero and a dead-time with both bridge inputs off.
- One shared PWM period counter serves all channels. Sits between the navigation FSM and the motor pins.

Parameters:
N_CH, 2, number of motor channels (1..8)
DUTY_W, 10, duty resolution in bits; full scale is 2**DUTY_W
CLK_HZ, 100_000_000, clk frequency
PWM_HZ, 25_000, PWM frequency; PERIOD = CLK_HZ/PWM_HZ (4000 at defaults)
RAMP_DIV, 100_000, clk cycles per ramp tick
RAMP_STEP, 8, duty change per ramp tick
DEAD_CYC, 1000, dead-time cycles with IN=00 on reversal

Ports:
clk  in  1  system clock
rst  in  1  async active-high reset
cmd_valid  in  1  command strobe
cmd_ready  out  1  command accepted when valid&ready
cmd_ch  in  max(1,$clog2(N_CH))  target channel
cmd_dir  in  2  00 stop, 10 forward, 01 backward, 11 brake
cmd_duty  in  DUTY_W  target duty
estop  in  1  emergency stop, level-sensitive
pwm  out  N_CH  PWM enable per channel
motor_in  out  2*N_CH  bridge IN pair per channel; channel k is bits [2k+1:2k]
busy  out  N_CH  channel is ramping, in dead-time, or has cur_duty different from target

Behaviour:
Reset:
- pwm, motor_in, busy are 0. All cur_duty, target and dir registers are 0.
- All channel FSMs are in IDLE. Period counter and ramp counter are 0.
- cmd_ready is 0 during rst and 1 in the first cycle after release.

Commands:
- cmd_ready = !estop.
- On valid&ready with cmd_ch < N_CH, the channel's tgt_dir and tgt_duty are loaded at the clock edge.
- cmd_ch >= N_CH is accepted and dropped.
- A new command overrides the pending target at any FSM state; the latest command wins.
- cmd_dir 00, or cmd_duty 0, is a stop request.

Period counter:
- Counts 0..PERIOD-1 and wraps.
- At cnt==PERIOD-1 each channel latches thr = (PERIOD*cur_duty) >> DUTY_W using a 32-bit product.
- pwm[k] is registered: pwm[k] = (cnt < thr_k). The threshold therefore only changes at period boundaries, so there are no glitches.
- Duty 0 gives pwm constantly 0. Duty 2**DUTY_W-1 gives a high time of PERIOD-4 cycles at defaults (3996).

Ramp tick:
- One-cycle pulse when the ramp counter reaches RAMP_DIV-1; the counter then wraps.
- Each tick moves cur_duty toward its target by RAMP_STEP, saturating exactly at the target with no overshoot and no wrap below 0.

Per-channel FSM (dir_q is the direction driven on motor_in):
- IDLE: motor_in=00, cur_duty=0. A non-stop target goes to RUN, with dir_q=tgt_dir loaded in the same cycle.
- RUN: motor_in=dir_q; ramp cur toward tgt_duty.
  - tgt_dir differs from dir_q and is not brake or stop → DECEL.
  - Stop request → DECEL.
  - Brake → BRAKE.
- DECEL: ramp cur toward 0. When cur==0, go to DEAD if a non-stop target is pending, otherwise IDLE.
- DEAD: motor_in=00 for DEAD_CYC cycles, then dir_q=tgt_dir → RUN.
  - A stop arriving during DEAD → IDLE at the end of the count.
- BRAKE: cur_duty=0 immediately, motor_in=11.
  - Any non-brake command → DEAD, then RUN or IDLE.

Priority and concurrency:
- estop has priority over everything. While high, all channels are forced in the same cycle to cur=0, thr=0, motor_in=00, state IDLE, and targets cleared.
- pwm drops to 0 within 1 cycle of estop.
- Simultaneous tick and command: the command is loaded and the tick uses the old target.
- Channels are independent; only the counters are shared.

Test Plan:
Sim parameters: PERIOD=4000, RAMP_DIV=4, RAMP_STEP=64, DEAD_CYC=16.
1. Reset, then cmd ch0 fwd duty 768 → motor_in[1:0]=10 next cycle; cur reaches 768 after 12 ticks (48 cycles); next period pwm[0] high exactly 3000 of 4000 cycles; busy[0] falls when cur==768.
2. While ch0 runs fwd at 768, cmd ch0 back 512 → cur ramps to 0; motor_in=00 for 16 cycles with pwm 0; then motor_in=01; ramps to 512; pwm high 2000/4000.
3. cmd ch1 brake while running 640 → same-edge cur=0, motor_in[3:2]=11, pwm[1] 0 within 1 cycle; ch0 unaffected.
4. estop asserted mid-ramp on both channels → motor_in=0000, pwm=00 next cycle, cmd_ready=0; a command during estop is ignored; after release, ch0 fwd 256 ramps from 0.
5. cmd_ch=3 with N_CH=2 → accepted and no output change. Three back-to-back commands to ch0 (fwd 100, fwd 900, fwd 50) → final target 50 with no intermediate overshoot.
6. Assert rst mid-DEAD → all outputs 0 immediately; after release the FSM is in IDLE and the pending target is lost.
